// File: rtl/uart_tx_arb.sv
// uart_tx_arb: locks one of two byte-stream requesters onto a UART transmit FIFO for a whole packet.
// Define UART_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed priority (req0 wins).
module uart_tx_arb #(
    parameter int DBIT    = 8,
    parameter int MAX_LEN = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic            req1_valid,
    input  logic [DBIT-1:0] req0_data,
    input  logic [DBIT-1:0] req1_data,
    input  logic            req0_last,
    input  logic            req1_last,
    output logic            req0_ready,
    output logic            req1_ready,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [DBIT-1:0] w_data,
    output logic [1:0]      grant,
    output logic            len_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]      state;
    logic [7:0]      cnt;
    logic            xfer;
    logic            win1;
    logic            last_b;
    logic            at_max;
    logic [DBIT-1:0] byte_d;

    // !wr_uart blocks a second write before tx_full can reflect the first one
    assign req0_ready = grant[0] && state == SEND && !tx_full && !wr_uart;
    assign req1_ready = grant[1] && state == SEND && !tx_full && !wr_uart;
    assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign byte_d     = grant[1] ? req1_data : req0_data;
    assign last_b     = grant[1] ? req1_last : req0_last;
    assign at_max     = cnt == 8'(MAX_LEN - 1);

`ifdef UART_ARB_RR_EN
    logic ptr;

    assign win1 = req1_valid && (!req0_valid || ptr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= 1'b0;
        else if (state == IDLE && (req0_valid || req1_valid))
            ptr <= !win1;
    end
`else
    assign win1 = req1_valid && !req0_valid;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant   <= 2'b00;
            cnt     <= 8'd0;
            wr_uart <= 1'b0;
            w_data  <= '0;
            len_err <= 1'b0;
        end else begin
            wr_uart <= xfer;
            len_err <= xfer && !last_b && at_max;
            if (xfer) begin
                w_data <= byte_d;
                cnt    <= cnt + 8'd1;
                if (last_b || at_max) begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            end else if (state == IDLE && (req0_valid || req1_valid)) begin
                state <= SEND;
                grant <= {win1, !win1};
                cnt   <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed table, corner-case sequences and randomized traffic against a packet-level model.
// Built with MAX_LEN=4 so forced releases are frequent; tie expectations follow UART_ARB_RR_EN.
module tb_uart_tx_arb;
    localparam int MAXL = 4;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } byte_t;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       tf;
        logic [1:0] g;
        logic       wr;
        logic [7:0] wd;
        logic       r0;
        logic       r1;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_last = 1'b0, req1_last = 1'b0;
    logic       req0_ready, req1_ready;
    logic       tx_full = 1'b0;
    logic       wr_uart;
    logic [7:0] w_data;
    logic [1:0] grant;
    logic       len_err;

    int tests = 0;
    int fails = 0;

    byte_t      q0[$], q1[$];
    logic [7:0] wlog[$];
    int         owner = -1;
    int         cnt = 0;
    bit         m_wr = 0, m_le = 0;
    logic [7:0] m_wd = 8'h00;
    int         gap_pct = 0, full_pct = 0;
    bit         bp = 0;
    int         le_seen = 0, wr_seen = 0;
`ifdef UART_ARB_RR_EN
    bit         ptr = 0;
`endif

    uart_tx_arb #(.DBIT(8), .MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_last(req0_last), .req1_last(req1_last),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .grant(grant), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: check what the last edge produced, drive new inputs, predict the coming edge.
    task automatic step();
        bit v0, v1, r0, r1;
        byte_t b;
        int win;
        @(negedge clk);
        chk("wr_uart", wr_uart, m_wr);
        chk("w_data", w_data, m_wd);
        chk("len_err", len_err, m_le);
        chk("grant", grant, owner < 0 ? 0 : (1 << owner));
        le_seen += int'(len_err);
        wr_seen += int'(wr_uart);
        v0 = q0.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct;
        v1 = q1.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct;
        req0_valid = v0;
        req1_valid = v1;
        if (q0.size() > 0) begin
            req0_data = q0[0].d;
            req0_last = q0[0].l;
        end
        if (q1.size() > 0) begin
            req1_data = q1[0].d;
            req1_last = q1[0].l;
        end
        tx_full = bp || int'($urandom_range(0, 99)) < full_pct;
        #1;
        r0 = owner == 0 && !tx_full && !m_wr;
        r1 = owner == 1 && !tx_full && !m_wr;
        chk("req0_ready", req0_ready, r0);
        chk("req1_ready", req1_ready, r1);
        m_le = 0;
        m_wr = (v0 && r0) || (v1 && r1);
        if (m_wr) begin
            b = r0 ? q0.pop_front() : q1.pop_front();
            m_wd = b.d;
            wlog.push_back(b.d);
            cnt++;
            m_le = !b.l && cnt == MAXL;
            if (b.l || cnt == MAXL) owner = -1;
        end else if (owner < 0 && (v0 || v1)) begin
`ifdef UART_ARB_RR_EN
            win = (v0 && v1) ? int'(ptr) : (v1 ? 1 : 0);
            ptr = (win == 0);
`else
            win = v0 ? 0 : 1;
`endif
            owner = win;
            cnt = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_wr_uart", wr_uart, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tx_full = 1'b0;
        q0.delete();
        q1.delete();
        owner = -1;
        cnt = 0;
        m_wr = 0;
        m_le = 0;
        m_wd = 8'h00;
`ifdef UART_ARB_RR_EN
        ptr = 0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || owner >= 0 || m_wr) && n < limit) begin
            step();
            n++;
        end
        chk("drain_in_budget", n < limit, 1);
    endtask

    task automatic push_pkt(input int who);
        int len = $urandom_range(1, 6);
        byte_t b;
        for (int k = 0; k < len; k++) begin
            b.d = 8'($urandom);
            b.l = (k == len - 1);
            if (who == 0) q0.push_back(b);
            else q1.push_back(b);
        end
    endtask

    task automatic chk_log(input string name, input int base, input logic [7:0] exp[$]);
        chk({name, "_count"}, wlog.size() - base, exp.size());
        for (int k = 0; k < exp.size() && base + k < wlog.size(); k++)
            chk(name, wlog[base + k], exp[k]);
    endtask

    initial begin
        vec_t vec[8];
        logic [7:0] exp_q[$];
        int base, ws, le0, n;
        vec[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        vec[1] = '{1'b1, 8'h41, 1'b0, 1'b0, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0};
        vec[2] = '{1'b1, 8'h42, 1'b0, 1'b0, 2'b01, 1'b1, 8'h41, 1'b0, 1'b0};
        vec[3] = '{1'b1, 8'h42, 1'b0, 1'b0, 2'b01, 1'b0, 8'h41, 1'b1, 1'b0};
        vec[4] = '{1'b1, 8'h43, 1'b1, 1'b0, 2'b01, 1'b1, 8'h42, 1'b0, 1'b0};
        vec[5] = '{1'b1, 8'h43, 1'b1, 1'b0, 2'b01, 1'b0, 8'h42, 1'b1, 1'b0};
        vec[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 8'h43, 1'b0, 1'b0};
        vec[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 8'h43, 1'b0, 1'b0};

        do_reset();
        foreach (vec[i]) begin
            @(negedge clk);
            req0_valid = vec[i].v0;
            req0_data  = vec[i].d0;
            req0_last  = vec[i].l0;
            req1_valid = 1'b0;
            tx_full    = vec[i].tf;
            #1;
            chk($sformatf("vec%0d_grant", i), grant, vec[i].g);
            chk($sformatf("vec%0d_wr_uart", i), wr_uart, vec[i].wr);
            chk($sformatf("vec%0d_w_data", i), w_data, vec[i].wd);
            chk($sformatf("vec%0d_ready0", i), req0_ready, vec[i].r0);
            chk($sformatf("vec%0d_ready1", i), req1_ready, vec[i].r1);
        end

        // ties: req0 has two packets queued, req1 one
        do_reset();
        base = wlog.size();
        q0.push_back('{8'h10, 1'b0});
        q0.push_back('{8'h11, 1'b1});
        q0.push_back('{8'h12, 1'b1});
        q1.push_back('{8'h20, 1'b1});
        drain(100);
`ifdef UART_ARB_RR_EN
        exp_q = '{8'h10, 8'h11, 8'h20, 8'h12};
`else
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h20};
`endif
        chk_log("tie_order", base, exp_q);

        // backpressure for 10 cycles mid-packet
        do_reset();
        base = wlog.size();
        for (int k = 0; k < 4; k++) q1.push_back('{8'hA0 + 8'(k), k == 3});
        n = 0;
        while (wlog.size() < base + 2 && n < 50) begin
            step();
            n++;
        end
        chk("bp_start_in_budget", n < 50, 1);
        bp = 1;
        step();
        ws = wr_seen;
        repeat (10) step();
        chk("bp_no_write", wr_seen - ws, 0);
        bp = 0;
        drain(100);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        chk_log("bp_bytes", base, exp_q);

        // overlength: 6 bytes without last, MAX_LEN=4
        do_reset();
        base = wlog.size();
        le0 = le_seen;
        for (int k = 0; k < 6; k++) q1.push_back('{8'hB0 + 8'(k), 1'b0});
        n = 0;
        while (q1.size() > 0 && n < 60) begin
            step();
            n++;
        end
        chk("ovl_in_budget", n < 60, 1);
        repeat (2) step();
        chk("ovl_len_err_pulses", le_seen - le0, 1);
        chk("ovl_new_pkt_grant", grant, 2'b10);
        q1.push_back('{8'hB6, 1'b1});
        drain(100);
        exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6};
        chk_log("ovl_bytes", base, exp_q);
        chk("ovl_len_err_total", le_seen - le0, 1);

        // reset after 2 of 5 bytes
        do_reset();
        base = wlog.size();
        for (int k = 0; k < 5; k++) q0.push_back('{8'hC0 + 8'(k), k == 4});
        n = 0;
        while (wlog.size() < base + 2 && n < 50) begin
            step();
            n++;
        end
        chk("rst_mid_in_budget", n < 50, 1);
        do_reset();
        ws = wr_seen;
        repeat (5) step();
        chk("rst_mid_idle_writes", wr_seen - ws, 0);
        chk("rst_mid_idle_grant", grant, 2'b00);

        // randomized traffic
        do_reset();
        gap_pct = 20;
        full_pct = 25;
        for (int it = 0; it < 600; it++) begin
            if (q0.size() < 3 && $urandom_range(0, 3) == 0) push_pkt(0);
            if (q1.size() < 3 && $urandom_range(0, 3) == 0) push_pkt(1);
            step();
        end
        gap_pct = 0;
        full_pct = 0;
        drain(500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
